// File: rtl/cdb_rr_scheduler_pkg.sv
// Helpers local to the CDB round-robin scheduler.
package cdb_rr_scheduler_pkg;

  // Increment an index modulo n (n >= 1).
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared processor definitions used by the CDB scheduler and its neighbours.
// Provides the XLEN/TRUE/FALSE macros and the execute write-back and CDB
// payload types.
`ifndef SYS_DEFS_SV
`define SYS_DEFS_SV

`define XLEN  32
`define TRUE  1'b1
`define FALSE 1'b0

package sys_defs;

  localparam int unsigned XLEN_W    = `XLEN;
  localparam int unsigned ROB_TAG_W = 5;

  typedef logic [31:0] INST;

  // Result offered by a functional unit at the end of execute.
  typedef struct packed {
    logic                 valid;
    logic [XLEN_W-1:0]    value;
    logic [ROB_TAG_W-1:0] rob_tag;
    INST                  inst;
    logic [XLEN_W-1:0]    NPC;
  } EX_WR_PACKET;

  // Common data bus broadcast.
  typedef struct packed {
    logic                 valid;
    logic [XLEN_W-1:0]    value;
    logic [ROB_TAG_W-1:0] rob_tag;
  } CDB_DATA;

endpackage

`endif

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester found searching
// upward from ptr, wrapping modulo N. Purely combinational.
//   req   - request vector, one bit per requester
//   ptr   - highest-priority index this cycle (must be < N)
//   grant - one-hot grant, all zero when no request is pending
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic        found;
  int unsigned idx;

  // Walk the N positions starting at ptr; the first request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_rr_scheduler.sv
// Common data bus scheduler: one holding entry per functional unit, drained
// onto the CDB one result per cycle in round-robin order.
//   clock, reset  - clock and synchronous active-high reset
//   squash        - flush: discards every pending result
//   ex_packet_in  - per-FU result offers
//   ex_ready      - per-FU accept (combinational)
//   cdb           - registered broadcast (valid, value, rob_tag)
//   wr_inst       - registered instruction of the broadcast, 0 when idle
//   wr_NPC        - registered NPC of the broadcast, 0 when idle
//   grant_idx     - registered FU index of the broadcast, 0 when idle
module cdb_rr_scheduler
  import sys_defs::*;
  import cdb_rr_scheduler_pkg::*;
#(
  parameter  int unsigned FU_NUM = 4,
  localparam int unsigned IDX_W  = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  EX_WR_PACKET [FU_NUM-1:0] ex_packet_in,
  output logic        [FU_NUM-1:0] ex_ready,
  output CDB_DATA                  cdb,
  output INST                      wr_inst,
  output logic        [`XLEN-1:0]  wr_NPC,
  output logic        [IDX_W-1:0]  grant_idx
);

  // Holding entries; the stored packet's valid bit is the entry-valid flag.
  EX_WR_PACKET [FU_NUM-1:0] buf_q, buf_d;
  logic        [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  CDB_DATA                  cdb_q, cdb_d;
  INST                      wr_inst_q, wr_inst_d;
  logic        [`XLEN-1:0]  wr_npc_q, wr_npc_d;
  logic        [IDX_W-1:0]  grant_idx_q, grant_idx_d;

  logic [FU_NUM-1:0] buf_valid_c;
  logic [FU_NUM-1:0] grant_c;
  logic [FU_NUM-1:0] ex_ready_c;
  logic [FU_NUM-1:0] accept_c;
  logic [IDX_W-1:0]  grant_enc_c;
  logic              grant_any_c;

  always_comb begin
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      buf_valid_c[i] = buf_q[i].valid;
    end
  end

  rr_arbiter #(.N(FU_NUM)) u_rr_arbiter (
    .req   (buf_valid_c),
    .ptr   (rr_ptr_q),
    .grant (grant_c)
  );

  // One-hot grant to index.
  always_comb begin
    grant_enc_c = '0;
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      if (grant_c[i]) grant_enc_c = IDX_W'(i);
    end
  end

  assign grant_any_c = |grant_c;

  // An entry being granted this cycle may be refilled on the same edge.
  assign ex_ready_c = {FU_NUM{~squash & ~reset}} & (~buf_valid_c | grant_c);

  always_comb begin
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      accept_c[i] = ex_packet_in[i].valid & ex_ready_c[i];
    end
  end

  // Next-state: broadcast selection and entry updates.
  always_comb begin
    buf_d       = buf_q;
    rr_ptr_d    = rr_ptr_q;
    cdb_d       = '0;
    wr_inst_d   = '0;
    wr_npc_d    = '0;
    grant_idx_d = '0;

    if (!squash && grant_any_c) begin
      cdb_d.valid   = `TRUE;
      cdb_d.value   = buf_q[grant_enc_c].value;
      cdb_d.rob_tag = buf_q[grant_enc_c].rob_tag;
      wr_inst_d     = buf_q[grant_enc_c].inst;
      wr_npc_d      = buf_q[grant_enc_c].NPC;
      grant_idx_d   = grant_enc_c;
      rr_ptr_d      = IDX_W'(wrap_inc(32'(grant_enc_c), FU_NUM));
    end

    for (int unsigned i = 0; i < FU_NUM; i++) begin
      if (squash) begin
        buf_d[i].valid = `FALSE;
      end else if (accept_c[i]) begin
        buf_d[i] = ex_packet_in[i];
      end else if (grant_c[i]) begin
        buf_d[i].valid = `FALSE;
      end
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q       <= '0;
      rr_ptr_q    <= '0;
      cdb_q       <= '0;
      wr_inst_q   <= '0;
      wr_npc_q    <= '0;
      grant_idx_q <= '0;
    end else begin
      buf_q       <= buf_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_q       <= cdb_d;
      wr_inst_q   <= wr_inst_d;
      wr_npc_q    <= wr_npc_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign ex_ready  = ex_ready_c;
  assign cdb       = cdb_q;
  assign wr_inst   = wr_inst_q;
  assign wr_NPC    = wr_npc_q;
  assign grant_idx = grant_idx_q;

endmodule
